// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access sequencer: access sizes, FSM states,
// the alignment rule and the width of the optional WAIT timeout counter.
package mem_access_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            default: bad = |offset;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_store_align.sv
// Combinational store lane alignment: byte enables from size/offset and
// lane-replicated write data. Loads never assert byte enables.
module mem_store_align
    import mem_access_pkg::*;
(
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wbe,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_wbe   = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SIZE_B: begin
                o_wbe   = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SIZE_H: begin
                o_wbe   = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wbe   = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
        if (!i_we) begin
            o_wbe = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and data memory (IDLE/ISSUE/WAIT/RESP).
// Define MEM_ACCESS_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [1:0]       i_req_size,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_mem_valid,
    input  logic             i_mem_ready,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_addr,
    output logic [3:0]       o_mem_wbe,
    output logic [31:0]      o_mem_wdata,
    input  logic             i_mem_rvalid,
    input  logic [31:0]      i_mem_rdata,
    output logic             o_rsp_valid,
    output logic [31:0]      o_rsp_rdata,
    output logic [1:0]       o_rsp_offset,
    output logic [1:0]       o_rsp_size,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_err
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mem_access_unit: TIMEOUT must be at least 2");
    end

    state_t           r_state;
    logic             r_req_ready;
    logic             r_mem_valid;
    logic             r_we;
    logic [1:0]       r_size;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [TAG_W-1:0] r_tag;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic [1:0]       r_rsp_offset;
    logic [1:0]       r_rsp_size;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_err;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] r_cnt;
`endif

    mem_store_align u_align (
        .i_we     (r_we),
        .i_size   (r_size),
        .i_offset (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .o_wbe    (o_mem_wbe),
        .o_wdata  (o_mem_wdata)
    );

    assign o_req_ready  = r_req_ready;
    assign o_mem_valid  = r_mem_valid;
    assign o_mem_we     = r_we;
    assign o_mem_addr   = {r_addr[31:2], 2'b00};
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_rsp_offset = r_rsp_offset;
    assign o_rsp_size   = r_rsp_size;
    assign o_rsp_tag    = r_rsp_tag;
    assign o_rsp_err    = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_offset <= 2'b00;
            r_rsp_size   <= 2'b00;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    // req_ready is itself a register, so nothing is taken the cycle after reset.
                    if (i_req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_we        <= i_req_we;
                        r_size      <= i_req_size;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_tag       <= i_req_tag;
                        if (is_misaligned(i_req_size, i_req_addr[1:0])) begin
                            r_state      <= ST_RESP;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_rdata  <= '0;
                            r_rsp_offset <= i_req_addr[1:0];
                            r_rsp_size   <= i_req_size;
                            r_rsp_tag    <= i_req_tag;
                            r_rsp_err    <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_mem_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_we) begin
                            r_state      <= ST_RESP;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_rdata  <= '0;
                            r_rsp_offset <= r_addr[1:0];
                            r_rsp_size   <= r_size;
                            r_rsp_tag    <= r_tag;
                            r_rsp_err    <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    // Read data takes priority over a timeout landing in the same cycle.
                    if (i_mem_rvalid) begin
                        r_state      <= ST_RESP;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= i_mem_rdata;
                        r_rsp_offset <= r_addr[1:0];
                        r_rsp_size   <= r_size;
                        r_rsp_tag    <= r_tag;
                        r_rsp_err    <= 1'b0;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (r_cnt == TERM) begin
                        r_state      <= ST_RESP;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= '0;
                        r_rsp_offset <= r_addr[1:0];
                        r_rsp_size   <= r_size;
                        r_rsp_tag    <= r_tag;
                        r_rsp_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_valid <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit plus hand sequences for reset,
// stale read data and the WAIT timeout (when MEM_ACCESS_TIMEOUT_EN is defined).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [1:0]  i_req_size = 2'b00;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic [4:0]  i_req_tag = '0;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wbe;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_offset;
    logic [1:0]  o_rsp_size;
    logic [4:0]  o_rsp_tag;
    logic        o_rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TAG_W(5), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_size   (i_req_size),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_tag    (i_req_tag),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wbe    (o_mem_wbe),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_offset (o_rsp_offset),
        .o_rsp_size   (o_rsp_size),
        .o_rsp_tag    (o_rsp_tag),
        .o_rsp_err    (o_rsp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        int          rdy_dly;
        int          rv_dly;
        logic [31:0] mrdata;
        logic        exp_mem;
        logic [3:0]  exp_wbe;
        logic [31:0] exp_mwdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int k = 0; k < 20 && o_req_ready !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        check({name, "_ready"}, {31'd0, o_req_ready}, 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int   issue_n;
        int   hs_c;
        int   lat;
        bit   hs;
        bit   saw_mem;
        bit   got;
        logic [4:0] tag_now;
        issue_n = 0; hs_c = 0; lat = 0; hs = 0; saw_mem = 0; got = 0;
        wait_ready(name);
        i_req_valid = 1'b1;
        i_req_we    = v.we;
        i_req_size  = v.size;
        i_req_addr  = v.addr;
        i_req_wdata = v.wdata;
        i_req_tag   = v.tag;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            i_mem_ready  = 1'b0;
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = 32'h0BAD_0BAD;
            if (o_rsp_valid === 1'b1) begin
                got = 1; lat = c;
                break;
            end
            if (o_mem_valid === 1'b1) begin
                saw_mem = 1;
                check({name, "_maddr"}, o_mem_addr, v.addr & 32'hFFFF_FFFC);
                check({name, "_mwbe"}, {28'd0, o_mem_wbe}, {28'd0, v.exp_wbe});
                check({name, "_mwe"}, {31'd0, o_mem_we}, {31'd0, v.we});
                if (v.we) check({name, "_mwdata"}, o_mem_wdata, v.exp_mwdata);
                if (issue_n >= v.rdy_dly) begin
                    i_mem_ready = 1'b1; hs = 1; hs_c = c;
                end
                issue_n++;
            end else if (hs && !v.we && (c - hs_c) >= v.rv_dly) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = v.mrdata;
            end
            @(posedge clk); #1;
        end
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        check({name, "_rsp_seen"}, {31'd0, got}, 32'd1);
        check({name, "_lat"}, lat, v.exp_lat);
        check({name, "_mem_seen"}, {31'd0, saw_mem}, {31'd0, v.exp_mem});
        check({name, "_rdata"}, o_rsp_rdata, v.exp_rdata);
        check({name, "_err"}, {31'd0, o_rsp_err}, {31'd0, v.exp_err});
        check({name, "_offset"}, {30'd0, o_rsp_offset}, {30'd0, v.addr[1:0]});
        check({name, "_size"}, {30'd0, o_rsp_size}, {30'd0, v.size});
        check({name, "_tag"}, {27'd0, o_rsp_tag}, {27'd0, v.tag});
        tag_now = o_rsp_tag;
        @(posedge clk); #1;
        check({name, "_pulse"}, {31'd0, o_rsp_valid}, 32'd0);
        check({name, "_b2b_ready"}, {31'd0, o_req_ready}, 32'd1);
        check({name, "_tag_hold"}, {27'd0, o_rsp_tag}, {27'd0, tag_now});
        $display("txn %s: we=%0b size=%0d addr=0x%08h tag=%0d lat=%0d rdata=0x%08h err=%0b",
                 name, v.we, v.size, v.addr, v.tag, lat, o_rsp_rdata, o_rsp_err);
    endtask

    task automatic reset_during(input bit in_wait, input string name);
        wait_ready(name);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_size  = 2'b10;
        i_req_addr  = 32'h0000_0500;
        i_req_tag   = 5'd21;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_mem_ready = in_wait;
        @(posedge clk); #1;
        i_mem_ready = 1'b0;
        check({name, "_pre_mvalid"}, {31'd0, o_mem_valid}, {31'd0, !in_wait});
        rst_n = 1'b0;
        #1;
        check({name, "_mvalid"}, {31'd0, o_mem_valid}, 32'd0);
        check({name, "_rvalid_out"}, {31'd0, o_rsp_valid}, 32'd0);
        check({name, "_ready_low"}, {31'd0, o_req_ready}, 32'd0);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h7777_7777;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check({name, "_ready_pre_edge"}, {31'd0, o_req_ready}, 32'd0);
        @(posedge clk); #1;
        check({name, "_ready_post_edge"}, {31'd0, o_req_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check({name, "_late_rvalid"}, {31'd0, o_rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        i_mem_rvalid = 1'b0;
        $display("txn %s: reset during %s, late rvalid ignored", name, in_wait ? "WAIT" : "ISSUE");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;
        //            we    size   addr          wdata         tag rdy rv  mrdata        mem   wbe      mwdata        lat rdata         err
        vecs[0]  = '{1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5, 5'd3,  0, 0, 32'h0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 2, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 2'b01, 32'h0000_2002, 32'h0,         5'd7,  3, 2, 32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0,         7, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 32'h0000_0006, 32'h0,         5'd31, 0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1, 32'h0,         1'b1};
        vecs[3]  = '{1'b1, 2'b01, 32'h0000_0102, 32'h1234_ABCD, 5'd4,  0, 0, 32'h0,         1'b1, 4'b1100, 32'hABCD_ABCD, 2, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 2'b10, 32'h0000_0200, 32'hCAFE_F00D, 5'd5,  1, 0, 32'h0,         1'b1, 4'b1111, 32'hCAFE_F00D, 3, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 2'b00, 32'h0000_0301, 32'h0,         5'd6,  0, 1, 32'h1122_3344, 1'b1, 4'b0000, 32'h0,         3, 32'h1122_3344, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 32'h0000_0005, 32'h0000_FFFF, 5'd8,  0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 2'b11, 32'h0000_0008, 32'h0,         5'd9,  0, 3, 32'h55AA_55AA, 1'b1, 4'b0000, 32'h0,         5, 32'h55AA_55AA, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 32'h0000_0009, 32'h0,         5'd10, 0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 2'b00, 32'h0000_0000, 32'hFFFF_FF7E, 5'd11, 0, 0, 32'h0,         1'b1, 4'b0001, 32'h7E7E_7E7E, 2, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 2'b10, 32'h0000_0040, 32'h0,         5'd12, 0, 4, 32'h1357_9BDF, 1'b1, 4'b0000, 32'h0,         6, 32'h1357_9BDF, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 32'h0000_0002, 32'h0000_003C, 5'd13, 2, 0, 32'h0,         1'b1, 4'b0100, 32'h3C3C_3C3C, 4, 32'h0,         1'b0};

        #2;
        check("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
        check("rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
        check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("rst_mem_wbe", {28'd0, o_mem_wbe}, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre_edge", {31'd0, o_req_ready}, 32'd0);
        @(posedge clk); #1;
        check("rel_ready_post_edge", {31'd0, o_req_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Stale read data while idle must not produce a response.
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hFEED_FACE;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stale_rvalid_rsp", {31'd0, o_rsp_valid}, 32'd0);
        end
        i_mem_rvalid = 1'b0;
        $display("txn stale: rvalid in IDLE ignored");

        reset_during(1'b0, "rst_issue");
        reset_during(1'b1, "rst_wait");

`ifdef MEM_ACCESS_TIMEOUT_EN
        tv = '{1'b0, 2'b10, 32'h0000_0080, 32'h0, 5'd14, 0, 1000, 32'h2468_ACE0, 1'b1, 4'b0000, 32'h0, 6, 32'h0, 1'b1};
        run_txn(tv, "timeout");
`else
        tv = '{1'b0, 2'b10, 32'h0000_0080, 32'h0, 5'd14, 0, 12, 32'h2468_ACE0, 1'b1, 4'b0000, 32'h0, 14, 32'h2468_ACE0, 1'b0};
        run_txn(tv, "long_wait");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access sequencer between the execute stage (ALU address, rs2 store data) and data memory; its response output feeds the load-extraction stage. It latches one load or store request, checks alignment, and generates the word-aligned address, byte enables and lane-replicated store data. It holds a valid/ready handshake with memory, captures the raw read word, and returns it with byte offset, size and register tag so the extractor can select and sign/zero-extend.

## Interface
- TAG_W, 5: width of destination-register tag carried through.
- TIMEOUT, 64: max WAIT cycles before timeout error (used only with timeout feature); must be ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_addr  in  32  byte address (ALU output).
- req_wdata  in  32  store data, right-justified.
- req_tag  in  TAG_W  destination register.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts request.
- mem_we  out  1  write strobe.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_wbe  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  raw read word.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  raw word (0 for stores and errors).
- rsp_offset  out  2  latched req_addr[1:0].
- rsp_size  out  2  latched req_size.
- rsp_tag  out  TAG_W  latched req_tag.
- rsp_err  out  1  misaligned or timed-out access.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch all request fields. Misaligned (half with addr[0]=1, or word with addr[1:0]≠0) → RESP with err=1; no memory traffic. Otherwise → ISSUE.
- ISSUE: mem_valid=1; mem_* fields stay stable until mem_ready. On mem_ready, a store → RESP and a load → WAIT.
- WAIT: on mem_rvalid, capture mem_rdata → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. No response backpressure.
- Byte enables: byte → 4'b0001<<offset, half → 4'b0011<<offset, word → 4'b1111. mem_wbe=0 for loads.
- Store data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
- mem_rvalid is ignored outside WAIT, including stale rvalid arriving in IDLE.
- rsp_* data outputs hold their last value outside RESP.

## Timing
- Reset, asynchronous: state=IDLE. All outputs are 0, including req_ready. req_ready is a register set to 1 on the first clk edge after rst_n rises.
- Reset mid-ISSUE or mid-WAIT drops mem_valid at once; the in-flight response is discarded.
- Accept at edge 0. Store with mem_ready already high: mem_valid is high in cycle 1 and rsp_valid in cycle 2.
- Load: memory must assert rvalid at the earliest one cycle after the handshake. The minimum is ISSUE c1, WAIT c2 with rvalid, rsp_valid c3.
- Misaligned request: rsp_valid in cycle 1 after accept.
- A new request can be accepted in the cycle after RESP, so back-to-back throughput is one access per 3 cycles minimum.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined: an 8-bit WAIT counter clears on entry to WAIT.
  - When the counter reaches TIMEOUT−1 without rvalid, the unit → RESP with rsp_err=1 and rsp_rdata=0.
  - If rvalid and the terminal count occur in the same cycle, the data wins and err=0.
- Undefined: WAIT persists until rvalid. rsp_err reflects only misalignment.

## Structure
- Package mem_access_pkg holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W;
  - state encoding;
  - a misalign-check function;
  - the TIMEOUT counter width.
- Sub-module mem_store_align: combinational size/offset/wdata → mem_wbe/mem_wdata. The FSM, latches and timeout counter stay in mem_access_unit.

## Test plan
- Store byte 0xA5 to 0x1003, mem_ready=1 → mem_wbe=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, rsp_valid cycle 2 with rdata=0 and err=0.
- Load half at 0x2002, mem_ready delayed 3 cycles, rvalid 2 cycles later with 0xDEADBEEF → mem_* stable throughout ISSUE; rsp_rdata=0xDEADBEEF, offset=2, size=01.
- Word load at 0x0006 → no mem_valid; rsp_valid cycle 1, err=1, tag echoed.
- Reset pulsed while in WAIT → mem_valid/rsp_valid low immediately; late rvalid ignored; req_ready=1 one edge after release.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT=4, load with no rvalid → rsp_valid, err=1, rdata=0 after 4 WAIT cycles.
- Back-to-back store then load with immediate memory → second accept occurs the cycle after first RESP; tags returned in order.
